wash_ctrl: RTL and testbench

- Downstream stage of the pre-wash setup block. It consumes the setup handshake (is_on, bal, mode) and runs the wash programme: charges the mode cost, then sequences WASH -> RINSE -> SPIN with a 1 s timebase.
- It exports the remaining programme time as 3 BCD digits for the shared 4-digit scanner, plus phase lamps, updated balance and done/error flags.

---
 rtl/wash_pkg.sv | 58 +++++
 rtl/wash_ctrl_bcd_down3.sv | 49 ++++
 rtl/wash_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wash_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and programme tables for the wash controller.
// Durations, costs and totals are indexed directly by the 2-bit mode.
package wash_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WASH  = 3'd1,
      RINSE = 3'd2,
      SPIN  = 3'd3,
      PAUSE = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [6:0]  WASH_SEC  [4] = '{7'd20, 7'd40, 7'd60, 7'd0};
   localparam logic [6:0]  RINSE_SEC [4] = '{7'd10, 7'd20, 7'd30, 7'd0};
   localparam logic [6:0]  SPIN_SEC  [4] = '{7'd10, 7'd20, 7'd30, 7'd30};
   localparam logic [2:0]  COST      [4] = '{3'd2, 3'd4, 3'd6, 3'd1};
   localparam logic [11:0] TOTAL_BCD [4] = '{12'h040, 12'h080, 12'h120, 12'h030};

   function automatic logic [6:0] phase_sec(state_t st, logic [1:0] m);
      logic [6:0] sec;
      case (st)
         WASH:    sec = WASH_SEC[m];
         RINSE:   sec = RINSE_SEC[m];
         SPIN:    sec = SPIN_SEC[m];
         default: sec = 7'd0;
      endcase
      return sec;
   endfunction

   // Phases with zero duration are skipped; IDLE yields the first phase.
   function automatic state_t next_phase(state_t cur, logic [1:0] m);
      state_t nx;
      logic has_w, has_r, has_s;
      has_w = (WASH_SEC[m]  != 7'd0);
      has_r = (RINSE_SEC[m] != 7'd0);
      has_s = (SPIN_SEC[m]  != 7'd0);
      case (cur)
         IDLE:    nx = has_w ? WASH : (has_r ? RINSE : (has_s ? SPIN : DONE));
         WASH:    nx = has_r ? RINSE : (has_s ? SPIN : DONE);
         RINSE:   nx = has_s ? SPIN : DONE;
         default: nx = DONE;
      endcase
      return nx;
   endfunction

   function automatic logic [2:0] phase_lamp(state_t st);
      logic [2:0] lamp;
      case (st)
         WASH:    lamp = 3'b001;
         RINSE:   lamp = 3'b010;
         SPIN:    lamp = 3'b100;
         default: lamp = 3'b000;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/wash_ctrl_bcd_down3.sv
// Three-digit BCD down-counter with load, decrement enable and zero flag.
// The count never wraps below 000.
module bcd_down3 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [11:0] load_val,
   input  logic        dec,
   output logic [11:0] value,
   output logic        zero
);

   logic [11:0] value_r;

   function automatic logic [11:0] bcd_dec(logic [11:0] v);
      logic [3:0] d2, d1, d0;
      {d2, d1, d0} = v;
      if (d0 != 4'd0) begin
         d0 = d0 - 4'd1;
      end else begin
         d0 = 4'd9;
         if (d1 != 4'd0) begin
            d1 = d1 - 4'd1;
         end else begin
            d1 = 4'd9;
            d2 = d2 - 4'd1;
         end
      end
      return {d2, d1, d0};
   endfunction

   // Count register: reset, then load has priority over decrement.
   always_ff @(posedge clk) begin
      if (!rst) begin
         value_r <= 12'h000;
      end else if (en) begin
         if (load) begin
            value_r <= load_val;
         end else if (dec && (value_r != 12'h000)) begin
            value_r <= bcd_dec(value_r);
         end
      end
   end

   assign value = value_r;
   assign zero  = (value_r == 12'h000);

endmodule

// File: rtl/wash_ctrl.sv
// Wash programme sequencer: charges the mode cost, then runs WASH -> RINSE -> SPIN
// on a 1 s timebase with pause support, and exports remaining time as BCD.
module wash_ctrl
   import wash_pkg::*;
#(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int DONE_HOLD   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        on,
   input  logic        start,
   input  logic        pause,
   input  logic        is_on,
   input  logic [10:0] bal,
   input  logic [1:0]  mode,
   output logic [10:0] bal_out,
   output logic [11:0] rem_bcd,
   output logic [2:0]  phase_light,
   output logic        busy,
   output logic        paused,
   output logic        done,
   output logic        err
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   state_t          state_r, state_nx_s, saved_r, saved_nx_s, phase_s;
   logic [1:0]      mode_r, mode_nx_s;
   logic [TW-1:0]   tick_r, tick_nx_s;
   logic [6:0]      sec_r, sec_nx_s;
   logic [7:0]      hold_r, hold_nx_s;
   logic [10:0]     bal_r, bal_nx_s;
   logic            err_r, err_nx_s;
   logic            busy_r, paused_r, done_r;
   logic [2:0]      lamp_r;
   logic            wrap_s, afford_s, load_s, dec_s, rem_zero_s;
   logic [11:0]     rem_s;

   // Next-state, counter and balance logic.
   always_comb begin
      state_nx_s = state_r;
      saved_nx_s = saved_r;
      mode_nx_s  = mode_r;
      tick_nx_s  = tick_r;
      sec_nx_s   = sec_r;
      hold_nx_s  = hold_r;
      bal_nx_s   = bal_r;
      err_nx_s   = err_r;
      load_s     = 1'b0;
      dec_s      = 1'b0;
      phase_s    = DONE;
      wrap_s     = (tick_r == TW'(TICK_CYCLES - 1));
      afford_s   = ($signed(bal) >= $signed({8'd0, COST[mode]}));
      case (state_r)
         IDLE: begin
            bal_nx_s = bal;
            if (start && is_on) begin
               if (afford_s) begin
                  phase_s    = next_phase(IDLE, mode);
                  state_nx_s = phase_s;
                  sec_nx_s   = phase_sec(phase_s, mode);
                  mode_nx_s  = mode;
                  bal_nx_s   = bal - {8'd0, COST[mode]};
                  err_nx_s   = 1'b0;
                  tick_nx_s  = {TW{1'b0}};
                  load_s     = 1'b1;
               end else begin
                  err_nx_s = 1'b1;
               end
            end else begin
               err_nx_s = err_r;
            end
         end
         WASH, RINSE, SPIN: begin
            tick_nx_s = wrap_s ? {TW{1'b0}} : tick_r + TW'(1);
            if (wrap_s) begin
               dec_s = 1'b1;
               if (sec_r <= 7'd1) begin
                  phase_s    = next_phase(state_r, mode_r);
                  state_nx_s = phase_s;
                  sec_nx_s   = phase_sec(phase_s, mode_r);
                  hold_nx_s  = 8'd0;
               end else begin
                  sec_nx_s = sec_r - 7'd1;
               end
            end else begin
               dec_s = 1'b0;
            end
            // The wrap decrement above lands first; pause then parks the resulting phase.
            if (pause && (state_nx_s != DONE)) begin
               saved_nx_s = state_nx_s;
               state_nx_s = PAUSE;
            end else begin
               saved_nx_s = saved_r;
            end
         end
         PAUSE: begin
            if (pause) begin
               state_nx_s = saved_r;
            end else begin
               state_nx_s = PAUSE;
            end
         end
         DONE: begin
            if (start) begin
               state_nx_s = IDLE;
               tick_nx_s  = {TW{1'b0}};
               hold_nx_s  = 8'd0;
            end else if (wrap_s) begin
               tick_nx_s = {TW{1'b0}};
               if (hold_r >= 8'(DONE_HOLD - 1)) begin
                  state_nx_s = IDLE;
                  hold_nx_s  = 8'd0;
               end else begin
                  hold_nx_s = hold_r + 8'd1;
               end
            end else begin
               tick_nx_s = tick_r + TW'(1);
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State and registered outputs; on=0 freezes everything except reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         saved_r  <= IDLE;
         mode_r   <= 2'd0;
         tick_r   <= {TW{1'b0}};
         sec_r    <= 7'd0;
         hold_r   <= 8'd0;
         bal_r    <= 11'd0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
         paused_r <= 1'b0;
         done_r   <= 1'b0;
         lamp_r   <= 3'b000;
      end else if (on) begin
         state_r  <= state_nx_s;
         saved_r  <= saved_nx_s;
         mode_r   <= mode_nx_s;
         tick_r   <= tick_nx_s;
         sec_r    <= sec_nx_s;
         hold_r   <= hold_nx_s;
         bal_r    <= bal_nx_s;
         err_r    <= err_nx_s;
         busy_r   <= (state_nx_s inside {WASH, RINSE, SPIN, PAUSE});
         paused_r <= (state_nx_s == PAUSE);
         done_r   <= (state_nx_s == DONE);
         lamp_r   <= phase_lamp((state_nx_s == PAUSE) ? saved_nx_s : state_nx_s);
      end
   end

   bcd_down3 u_rem (
      .clk      (clk),
      .rst      (rst),
      .en       (on),
      .load     (load_s),
      .load_val (TOTAL_BCD[mode]),
      .dec      (dec_s && !rem_zero_s),
      .value    (rem_s),
      .zero     (rem_zero_s)
   );

   assign bal_out     = bal_r;
   assign rem_bcd     = rem_s;
   assign phase_light = lamp_r;
   assign busy        = busy_r;
   assign paused      = paused_r;
   assign done        = done_r;
   assign err         = err_r;

endmodule

// File: tb/tb_wash_ctrl.sv
// Scoreboard bench for wash_ctrl: a seconds-level reference model predicts every
// post-edge output; a negedge monitor pops and compares.
module tb_wash_ctrl;

   localparam int T    = 10;
   localparam int HOLD = 3;

   logic        clk = 1'b0;
   logic        rst, on, start, pause, is_on;
   logic [10:0] bal;
   logic [1:0]  mode;
   logic [10:0] bal_out;
   logic [11:0] rem_bcd;
   logic [2:0]  phase_light;
   logic        busy, paused, done, err;

   wash_ctrl #(.TICK_CYCLES(T), .DONE_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .on(on), .start(start), .pause(pause), .is_on(is_on),
      .bal(bal), .mode(mode), .bal_out(bal_out), .rem_bcd(rem_bcd),
      .phase_light(phase_light), .busy(busy), .paused(paused), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] bal_out;
      logic [11:0] rem;
      logic [2:0]  lamp;
      logic        busy, paused, done, err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   passed = 0;

   // Reference model: 0 idle, 1 running, 2 paused, 3 done; time kept as seconds left.
   int W_S[4] = '{20, 40, 60, 0};
   int R_S[4] = '{10, 20, 30, 0};
   int S_S[4] = '{10, 20, 30, 30};
   int C_S[4] = '{2, 4, 6, 1};
   int m_st = 0, m_rem = 0, m_tick = 0, m_hold = 0, m_bal = 0, m_mode = 0;
   bit m_err = 1'b0;

   function automatic void model_step();
      int cst;
      cst = C_S[mode];
      if (!rst) begin
         m_st = 0; m_rem = 0; m_tick = 0; m_hold = 0; m_bal = 0; m_err = 1'b0;
         return;
      end
      if (!on) return;
      case (m_st)
         0: begin
            if (start && is_on) begin
               if (int'(bal) >= cst) begin
                  m_mode = int'(mode);
                  m_bal  = int'(bal) - cst;
                  m_rem  = W_S[m_mode] + R_S[m_mode] + S_S[m_mode];
                  m_tick = 0; m_err = 1'b0; m_st = 1;
               end else begin
                  m_err = 1'b1; m_bal = int'(bal);
               end
            end else begin
               m_bal = int'(bal);
            end
         end
         1: begin
            if (m_tick == T - 1) begin
               m_tick = 0;
               m_rem  = m_rem - 1;
               if (m_rem == 0) begin m_st = 3; m_hold = 0; end
            end else begin
               m_tick = m_tick + 1;
            end
            if (pause && m_st == 1) m_st = 2;
         end
         2: if (pause) m_st = 1;
         3: begin
            if (start) m_st = 0;
            else if (m_tick == T - 1) begin
               m_tick = 0;
               m_hold = m_hold + 1;
               if (m_hold == HOLD) m_st = 0;
            end else m_tick = m_tick + 1;
         end
         default: m_st = 0;
      endcase
   endfunction

   function automatic exp_t model_out();
      exp_t x;
      int s, r;
      s = S_S[m_mode];
      r = R_S[m_mode];
      x.bal_out = 11'(m_bal);
      x.rem     = {4'(m_rem / 100), 4'((m_rem / 10) % 10), 4'(m_rem % 10)};
      if (m_st == 1 || m_st == 2)
         x.lamp = (m_rem > r + s) ? 3'b001 : ((m_rem > s) ? 3'b010 : 3'b100);
      else
         x.lamp = 3'b000;
      x.busy   = (m_st == 1 || m_st == 2);
      x.paused = (m_st == 2);
      x.done   = (m_st == 3);
      x.err    = m_err;
      return x;
   endfunction

   function automatic void chk(string nm, logic [11:0] act, logic [11:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
   endfunction

   // Monitor: compare DUT outputs against the oldest prediction.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("bal_out",     12'(bal_out),     12'(e.bal_out));
         chk("rem_bcd",     rem_bcd,          e.rem);
         chk("phase_light", 12'(phase_light), 12'(e.lamp));
         chk("busy",        12'(busy),        12'(e.busy));
         chk("paused",      12'(paused),      12'(e.paused));
         chk("done",        12'(done),        12'(e.done));
         chk("err",         12'(err),         12'(e.err));
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      q.push_back(model_out());
      #1;
      start = 1'b0;
      pause = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst = 1'b0; on = 1'b1; start = 1'b0; pause = 1'b0; is_on = 1'b1;
      bal = 11'd0; mode = 2'd0;
      run(3);
      rst = 1'b1;
      cyc();
      // Standard programme end to end, including done hold and return to idle.
      bal = 11'd10; mode = 2'd1; start = 1'b1;
      cyc();
      run(80 * T + HOLD * T + 20);
      // Insufficient balance, then a funded heavy run reset mid-rinse.
      bal = 11'd3; mode = 2'd2; start = 1'b1;
      cyc();
      run(5);
      bal = 11'd6; start = 1'b1;
      cyc();
      run(70 * T);
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      run(3);
      // Spin-only programme; start inside DONE returns to idle only.
      bal = 11'd5; mode = 2'd3; start = 1'b1;
      cyc();
      run(32 * T);
      start = 1'b1;
      cyc();
      run(5);
      // Quick programme paused at 025, held, resumed.
      bal = 11'd9; mode = 2'd0; start = 1'b1;
      cyc();
      for (int i = 0; i < 1000 && m_rem != 25; i++) cyc();
      pause = 1'b1;
      cyc();
      run(50);
      pause = 1'b1;
      cyc();
      run(20);
      // Clock enable low with a dropped pause pulse inside the window.
      on = 1'b0;
      run(10);
      pause = 1'b1;
      cyc();
      run(19);
      on = 1'b1;
      run(15);
      // Pause landing exactly on the tick-wrap cycle.
      for (int i = 0; i < T && m_tick != T - 1; i++) cyc();
      pause = 1'b1;
      cyc();
      run(7);
      pause = 1'b1; start = 1'b1;
      cyc();
      run(45 * T);
      // Simultaneous start and pause in idle: start wins.
      bal = 11'd100; mode = 2'd0; start = 1'b1; pause = 1'b1;
      cyc();
      run(25);
      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 499) != 0);
         on    = ($urandom_range(0, 9) != 0);
         start = ($urandom_range(0, 24) == 0);
         pause = ($urandom_range(0, 29) == 0);
         is_on = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0)
            bal = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 8))
                                              : 11'($urandom_range(0, 999));
         mode = 2'($urandom_range(0, 3));
         cyc();
      end
      rst = 1'b1; on = 1'b1;
      run(2);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
